// File: rtl/alu_4bit_if.sv
// Operand/result bundle for the 4-bit ALU.
// master drives A, B, OP_SEL and receives Y, Carry (and Zero, Negative,
// Overflow when ALU_4BIT_FLAGS_EN is defined); slave is the ALU side.
interface alu_4bit_if;
    logic [3:0] A;
    logic [3:0] B;
    logic [3:0] OP_SEL;
    logic [3:0] Y;
    logic       Carry;
`ifdef ALU_4BIT_FLAGS_EN
    logic       Zero;
    logic       Negative;
    logic       Overflow;

    modport master (
        output A, B, OP_SEL,
        input  Y, Carry, Zero, Negative, Overflow
    );
    modport slave (
        input  A, B, OP_SEL,
        output Y, Carry, Zero, Negative, Overflow
    );
`else
    modport master (
        output A, B, OP_SEL,
        input  Y, Carry
    );
    modport slave (
        input  A, B, OP_SEL,
        output Y, Carry
    );
`endif
endinterface

// File: rtl/alu_4bit.sv
// Registered 4-bit ALU: 16 operations, one result per clock, latency 1.
// Ports: clk, rst (sync, active-high), bus (alu_4bit_if.slave: A, B,
// OP_SEL in; Y, Carry out). Define ALU_4BIT_FLAGS_EN to add the
// registered Zero, Negative and Overflow status flags.
module alu_4bit (
    input logic       clk,
    input logic       rst,
    alu_4bit_if.slave bus
);
    localparam logic [3:0] OP_ADD  = 4'd0;
    localparam logic [3:0] OP_SUB  = 4'd1;
    localparam logic [3:0] OP_INC  = 4'd2;
    localparam logic [3:0] OP_DEC  = 4'd3;
    localparam logic [3:0] OP_AND  = 4'd4;
    localparam logic [3:0] OP_OR   = 4'd5;
    localparam logic [3:0] OP_XOR  = 4'd6;
    localparam logic [3:0] OP_NOTA = 4'd7;
    localparam logic [3:0] OP_NAND = 4'd8;
    localparam logic [3:0] OP_NOR  = 4'd9;
    localparam logic [3:0] OP_XNOR = 4'd10;
    localparam logic [3:0] OP_SHL  = 4'd11;
    localparam logic [3:0] OP_SHR  = 4'd12;
    localparam logic [3:0] OP_ROL  = 4'd13;
    localparam logic [3:0] OP_ROR  = 4'd14;
    localparam logic [3:0] OP_CMP  = 4'd15;

    logic [3:0] a;
    logic [3:0] b;

    // 5-bit sums: bit 4 is carry-out for add/inc, borrow for sub/dec
    logic [4:0] add_w;
    logic [4:0] sub_w;
    logic [4:0] inc_w;
    logic [4:0] dec_w;

    logic [3:0] y_d;
    logic [3:0] y_q;
    logic       carry_d;
    logic       carry_q;

    assign a = bus.A;
    assign b = bus.B;

    assign add_w = {1'b0, a} + {1'b0, b};
    assign sub_w = {1'b0, a} - {1'b0, b};
    assign inc_w = {1'b0, a} + 5'd1;
    assign dec_w = {1'b0, a} - 5'd1;

    always_comb begin
        y_d     = 4'h0;
        carry_d = 1'b0;
        unique case (bus.OP_SEL)
            OP_ADD: begin
                y_d     = add_w[3:0];
                carry_d = add_w[4];
            end
            OP_SUB: begin
                y_d     = sub_w[3:0];
                carry_d = sub_w[4];
            end
            OP_INC: begin
                y_d     = inc_w[3:0];
                carry_d = inc_w[4];
            end
            OP_DEC: begin
                y_d     = dec_w[3:0];
                carry_d = dec_w[4];
            end
            OP_AND:  y_d = a & b;
            OP_OR:   y_d = a | b;
            OP_XOR:  y_d = a ^ b;
            OP_NOTA: y_d = ~a;
            OP_NAND: y_d = ~(a & b);
            OP_NOR:  y_d = ~(a | b);
            OP_XNOR: y_d = ~(a ^ b);
            OP_SHL: begin
                y_d     = {a[2:0], 1'b0};
                carry_d = a[3];
            end
            OP_SHR: begin
                y_d     = {1'b0, a[3:1]};
                carry_d = a[0];
            end
            OP_ROL: begin
                y_d     = {a[2:0], a[3]};
                carry_d = a[3];
            end
            OP_ROR: begin
                y_d     = {a[0], a[3:1]};
                carry_d = a[0];
            end
            OP_CMP: begin
                y_d = {1'b0, (a < b), (a > b), (a == b)};
            end
            default: begin
                y_d     = 4'h0;
                carry_d = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            y_q     <= 4'h0;
            carry_q <= 1'b0;
        end else begin
            y_q     <= y_d;
            carry_q <= carry_d;
        end
    end

    assign bus.Y     = y_q;
    assign bus.Carry = carry_q;

`ifdef ALU_4BIT_FLAGS_EN
    logic zero_d;
    logic zero_q;
    logic neg_d;
    logic neg_q;
    logic ovf_d;
    logic ovf_q;

    // Signed overflow: operands agree in sign (add) or differ (sub)
    // and the result sign departs from A. Inc/dec only wrap at 7/8.
    always_comb begin
        zero_d = (y_d == 4'h0);
        neg_d  = y_d[3];
        ovf_d  = 1'b0;
        unique case (bus.OP_SEL)
            OP_ADD:  ovf_d = (a[3] == b[3]) && (add_w[3] != a[3]);
            OP_SUB:  ovf_d = (a[3] != b[3]) && (sub_w[3] != a[3]);
            OP_INC:  ovf_d = (a == 4'h7);
            OP_DEC:  ovf_d = (a == 4'h8);
            default: ovf_d = 1'b0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            zero_q <= 1'b0;
            neg_q  <= 1'b0;
            ovf_q  <= 1'b0;
        end else begin
            zero_q <= zero_d;
            neg_q  <= neg_d;
            ovf_q  <= ovf_d;
        end
    end

    assign bus.Zero     = zero_q;
    assign bus.Negative = neg_q;
    assign bus.Overflow = ovf_q;
`endif

endmodule

// File: tb/tb_alu_4bit.sv
// Scoreboard bench for alu_4bit: directed vectors plus random traffic
// checked against an arithmetic reference model.
module tb_alu_4bit;
    logic clk;
    logic rst;

    alu_4bit_if bus ();

    alu_4bit dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    typedef struct {
        logic [3:0] y;
        logic       c;
        logic       z;
        logic       n;
        logic       v;
        logic [3:0] a;
        logic [3:0] b;
        logic [3:0] op;
        bit         r;
    } exp_t;

    exp_t q[$];
    int checks = 0;
    int errors = 0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic int sgn(int x);
        return (x > 7) ? x - 16 : x;
    endfunction

    function automatic exp_t model(int a, int b, int op, bit r);
        exp_t e;
        int y;
        int s;
        bit c;
        bit v;
        logic [3:0] la;
        logic [3:0] lb;
        la = 4'(a);
        lb = 4'(b);
        y = 0;
        c = 0;
        v = 0;
        case (op)
            0: begin
                y = (a + b) % 16;
                c = (a + b) > 15;
                s = sgn(a) + sgn(b);
                v = (s > 7) || (s < -8);
            end
            1: begin
                y = (a - b + 16) % 16;
                c = a < b;
                s = sgn(a) - sgn(b);
                v = (s > 7) || (s < -8);
            end
            2: begin
                y = (a + 1) % 16;
                c = (a == 15);
                v = (sgn(a) + 1) > 7;
            end
            3: begin
                y = (a + 15) % 16;
                c = (a == 0);
                v = (sgn(a) - 1) < -8;
            end
            4:  y = int'(la & lb);
            5:  y = int'(la | lb);
            6:  y = int'(la ^ lb);
            7:  y = 15 - a;
            8:  y = 15 - int'(la & lb);
            9:  y = 15 - int'(la | lb);
            10: y = 15 - int'(la ^ lb);
            11: begin
                y = (a * 2) % 16;
                c = a >= 8;
            end
            12: begin
                y = a / 2;
                c = a % 2;
            end
            13: begin
                y = (a * 2) % 16 + a / 8;
                c = a >= 8;
            end
            14: begin
                y = a / 2 + (a % 2) * 8;
                c = a % 2;
            end
            default: y = (a == b) ? 1 : ((a > b) ? 2 : 4);
        endcase
        if (r) begin
            y = 0;
            c = 0;
            v = 0;
        end
        e.y  = 4'(y);
        e.c  = c;
        e.z  = r ? 1'b0 : (y == 0);
        e.n  = r ? 1'b0 : (y >= 8);
        e.v  = v;
        e.a  = la;
        e.b  = lb;
        e.op = 4'(op);
        e.r  = r;
        return e;
    endfunction

    task automatic issue(int a, int b, int op, bit r);
        @(negedge clk);
        rst        = r;
        bus.A      = 4'(a);
        bus.B      = 4'(b);
        bus.OP_SEL = 4'(op);
        q.push_back(model(a, b, op, r));
    endtask

    // Monitor: every edge registers a new result, so each edge after a
    // pushed stimulus pops exactly one expectation.
    initial begin
        exp_t e;
        bit bad;
        forever begin
            @(posedge clk);
            #1;
            if (q.size() > 0) begin
                e = q.pop_front();
                checks++;
                bad = (bus.Y !== e.y) || (bus.Carry !== e.c);
`ifdef ALU_4BIT_FLAGS_EN
                bad = bad || (bus.Zero !== e.z) ||
                      (bus.Negative !== e.n) ||
                      (bus.Overflow !== e.v);
                if (bad) begin
                    errors++;
                    $display("FAIL op%0d a=%h b=%h rst=%0d: got y=%h c=%b z=%b n=%b v=%b want y=%h c=%b z=%b n=%b v=%b",
                             e.op, e.a, e.b, e.r, bus.Y, bus.Carry,
                             bus.Zero, bus.Negative, bus.Overflow,
                             e.y, e.c, e.z, e.n, e.v);
                end
`else
                if (bad) begin
                    errors++;
                    $display("FAIL op%0d a=%h b=%h rst=%0d: got y=%h c=%b want y=%h c=%b",
                             e.op, e.a, e.b, e.r, bus.Y, bus.Carry,
                             e.y, e.c);
                end
`endif
            end
        end
    end

    initial begin
        rst        = 1'b1;
        bus.A      = 4'h0;
        bus.B      = 4'h0;
        bus.OP_SEL = 4'h0;

        // reset with non-zero inputs must still give zeros
        issue(9, 6, 0, 1'b1);

        // A=5, B=3 through every opcode
        for (int op = 0; op < 16; op++)
            issue(5, 3, op, 1'b0);

        issue(15, 1, 0, 1'b0);
        issue(3, 5, 1, 1'b0);
        issue(0, 0, 3, 1'b0);
        issue(7, 1, 0, 1'b0);
        issue(9, 9, 15, 1'b0);
        issue(15, 0, 2, 1'b0);
        issue(8, 0, 3, 1'b0);
        issue(8, 1, 1, 1'b0);

        // reset in the middle of an ADD sweep, then resume
        for (int i = 0; i < 8; i++)
            issue(i + 4, i, 0, (i == 3) || (i == 4));

        for (int i = 0; i < 300; i++)
            issue($urandom_range(15), $urandom_range(15),
                  $urandom_range(15), ($urandom_range(31) == 0));

        repeat (3) @(posedge clk);
        #2;
        checks++;
        if (q.size() != 0) begin
            errors++;
            $display("FAIL drain: got %0d pending, want 0", q.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/alu_4bit.md
ALU_4BIT -- requirements
Module: alu_4bit

Interface
REQ-001 The block SHALL have no parameters; all widths are fixed at 4 bits.
REQ-002 clk  input  1  single clock; all state updates on its rising edge.
REQ-003 rst  input  1  synchronous, active-high reset.
REQ-004 A  input  4  operand A, unsigned (two's complement when used for flags).
REQ-005 B  input  4  operand B.
REQ-006 OP_SEL  input  4  operation select, codes 0-15.
REQ-007 Y  output  4  registered result.
REQ-008 Carry  output  1  registered carry/borrow/shift-out bit.
REQ-009 Zero, Negative, Overflow  output  1 each  registered status flags; present only per REQ-024.

Function
REQ-010 Each rising clk edge with rst=0 SHALL register the result of the current A, B, OP_SEL into Y and Carry (latency 1 cycle, a new operation every cycle, no handshake).
REQ-011 OP_SEL 0 ADD: Y=(A+B) mod 16; Carry=bit 4 of A+B.
REQ-012 OP_SEL 1 SUB: Y=(A-B) mod 16; Carry=1 if A<B (borrow), else 0.
REQ-013 OP_SEL 2 INC: Y=(A+1) mod 16; Carry=1 if A=15. OP_SEL 3 DEC: Y=(A-1) mod 16; Carry=1 if A=0.
REQ-014 OP_SEL 4-10 SHALL be AND, OR, XOR, NOT A, NAND, NOR, XNOR (bitwise, in that order); Carry=0.
REQ-015 OP_SEL 11 SHL: Y={A[2:0],0}, Carry=A[3]. OP_SEL 12 SHR: Y={0,A[3:1]}, Carry=A[0].
REQ-016 OP_SEL 13 ROL: Y={A[2:0],A[3]}, Carry=A[3]. OP_SEL 14 ROR: Y={A[0],A[3:1]}, Carry=A[0].
REQ-017 OP_SEL 15 CMP (unsigned): Y[0]=(A==B), Y[1]=(A>B), Y[2]=(A<B), Y[3]=0; Carry=0.
REQ-018 Result computation SHALL be purely combinational from current inputs; no dependency on previous Y or Carry.
REQ-019 Input changes between edges SHALL NOT affect outputs until the next rising edge.

Reset
REQ-020 rst=1 at a rising edge SHALL set Y=0, Carry=0 and all flags to 0, regardless of A, B, OP_SEL.
REQ-021 rst SHALL take priority over the operation computed in the same cycle; asserting rst mid-sequence discards that cycle's result.
REQ-022 The first edge with rst=0 after reset SHALL register the then-current operation normally.
REQ-023 Outputs before the first reset edge are undefined; benches SHALL apply reset first.

Configuration
REQ-024 Macro ALU_4BIT_FLAGS_EN defined: ports Zero, Negative, Overflow SHALL exist and register with Y: Zero=(Y==0), Negative=Y[3], Overflow=signed two's complement overflow for ADD/SUB/INC/DEC, else 0.
REQ-025 Macro ALU_4BIT_FLAGS_EN undefined: the three flag ports and their logic SHALL be absent; Y and Carry behaviour unchanged.

Verification
REQ-026 rst 1 cycle, then A=5, B=3, OP_SEL 0..15 one per cycle -> Y one cycle later: 8,2,6,4,1,7,6,A,E,8,9,A,2,A,A,2 (hex); Carry: 0,0,0,0,0,0,0,0,0,0,0,0,1,0,1,0.
REQ-027 A=15, B=1, ADD -> Y=0, Carry=1; with flags: Zero=1, Overflow=0, Negative=0.
REQ-028 A=3, B=5, SUB -> Y=E, Carry=1; A=0, DEC -> Y=F, Carry=1; with flags Negative=1 both.
REQ-029 A=7, B=1, ADD with flags -> Y=8, Overflow=1, Negative=1, Carry=0.
REQ-030 A=B=9, CMP -> Y=1; then rst=1 during a running ADD sweep -> next edge Y=0, Carry=0, flags 0; rst released -> operations resume with 1-cycle latency.
